dsm_interp_feeder: RTL and testbench
====================================

DSM_INTERP_FEEDER -- requirements
Module: dsm_interp_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning signed sample width on input and output.
REQ-002 SHALL have parameter OSR_LOG2, default 6, meaning log2 of oversampling ratio; OSR = 2^OSR_LOG2 DSM clocks per input sample; legal 1..10.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning input sample buffer entries; power of two, >= 2.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_en, input, 1, run enable.
REQ-007 SHALL have port i_valid, input, 1, upstream sample valid.
REQ-008 SHALL have port i_data, input, DATA_WIDTH signed, upstream sample.
REQ-009 SHALL have port o_ready, output, 1, FIFO can accept a sample.
REQ-010 SHALL have port o_sample, output, 1, DSM sample strobe (drives DSM i_sample).
REQ-011 SHALL have port o_data, output, DATA_WIDTH signed, interpolated value (drives DSM i_data).
REQ-012 SHALL have port o_underrun, output, 1, sticky FIFO-empty-at-fetch flag.
REQ-013 SHALL have port o_level, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.

Function
REQ-014 SHALL accept a push when i_valid && o_ready; o_ready = (o_level < FIFO_DEPTH), from registered count; no bypass from input to a same-cycle pop.
REQ-015 SHALL implement FSM IDLE -> LOAD_CUR -> LOAD_NEXT -> RUN; IDLE leaves only when i_en=1 and o_level >= 2.
REQ-016 SHALL pop into register cur in LOAD_CUR and into register next in LOAD_NEXT, one pop per cycle.
REQ-017 SHALL in RUN assert o_sample=1 every cycle and keep phase counter p (OSR_LOG2 bits) starting at 0, incrementing by 1, wrapping 2^OSR_LOG2-1 -> 0.
REQ-018 SHALL drive registered o_data = (cur*2^OSR_LOG2 + delta*p) >>> OSR_LOG2, delta = next - cur as DATA_WIDTH+1 signed, accumulator DATA_WIDTH+OSR_LOG2+1 signed, arithmetic (floor) shift; no saturation needed since result lies between cur and next.
REQ-019 SHALL on the cycle p = 2^OSR_LOG2-1 load cur <= next and, if FIFO non-empty, pop into next; first o_data of the new period equals the old next exactly.
REQ-020 SHALL on fetch with FIFO empty keep next unchanged (delta becomes 0, output holds last value), set o_underrun, and stay in RUN.
REQ-021 SHALL allow simultaneous push and pop in one cycle; o_level unchanged then.
REQ-022 SHALL return to IDLE on the cycle after i_en=0 from any state, forcing o_sample=0, o_data=0, p=0, clearing o_underrun; FIFO contents retained.
REQ-023 SHALL hold o_sample=0 and o_data=0 in IDLE, LOAD_CUR, LOAD_NEXT.
REQ-024 SHALL emit first o_sample=1 one cycle after LOAD_NEXT, with o_data = first sample.

Reset
REQ-025 SHALL on i_rst_n=0 asynchronously set state IDLE, FIFO empty (o_level=0, o_ready=1), o_sample=0, o_data=0, o_underrun=0, p=0, cur=next=0.
REQ-026 SHALL discard all buffered samples on reset mid-RUN and restart only via REQ-015.

Configuration
REQ-027 SHALL compile linear interpolation per REQ-018 when macro DSM_INTERP_LINEAR_EN is defined.
REQ-028 SHALL without DSM_INTERP_LINEAR_EN implement zero-order hold: o_data = cur for all p; FSM, fetch timing, underrun, and ports unchanged.

Verification
REQ-029 SHALL cover: OSR_LOG2=2, linear, push 0 then 100, i_en=1 -> o_data 0,25,50,75, then 100 on next period's p=0.
REQ-030 SHALL cover: OSR_LOG2=2, linear, push 0 then -3 -> o_data 0,-1,-2,-3 (floor rounding).
REQ-031 SHALL cover: push 5 samples with FIFO_DEPTH=4, i_en=0 -> o_ready=0 after 4th, o_level=4, 5th not accepted until a pop.
REQ-032 SHALL cover: RUN with no further pushes -> o_underrun=1 at first empty fetch, o_data holds last sample, o_sample stays 1; i_en=0 clears flag.
REQ-033 SHALL cover: assert i_rst_n=0 mid-RUN at p=2 -> outputs 0 immediately, o_level=0; macro undefined -> samples 0,100 give o_data 0,0,0,0,100.

Source files
------------

// File: rtl/dsm_interp_feeder.sv
// Purpose: buffers upstream samples and feeds a DSM one value per clock over 2^OSR_LOG2 clocks per sample;
//          define DSM_INTERP_LINEAR_EN for linear interpolation, otherwise each sample is held (zero-order hold).
// Latency: first o_sample three clocks after IDLE sees i_en=1 with o_level>=2. Backpressure: o_ready=0 while the buffer is full.
module dsm_interp_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int OSR_LOG2   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic                         i_valid,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    output logic                         o_ready,
    output logic                         o_sample,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_underrun,
    output logic [$clog2(FIFO_DEPTH):0]  o_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0]       DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]       TWO_L   = LW'(2);
    localparam logic [OSR_LOG2-1:0] P_LAST  = '1;

    typedef enum logic [1:0] {IDLE, LOAD_CUR, LOAD_NEXT, RUN} state_t;

    // Sample buffer
    logic signed [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]                level_q, level_d;
    logic                         push;
    logic                         pop;
    logic signed [DATA_WIDTH-1:0] head;

    // Interpolator state
    state_t                       state_q, state_d;
    logic signed [DATA_WIDTH-1:0] cur_q, cur_d;
    logic signed [DATA_WIDTH-1:0] next_q, next_d;
    logic [OSR_LOG2-1:0]          p_q, p_d;
    logic                         underrun_q, underrun_d;
    logic                         sample_q, sample_d;
    logic signed [DATA_WIDTH-1:0] data_q, data_d;

    // Readiness comes from the registered count only, so a sample pushed this cycle
    // can never be popped in the same cycle.
    assign o_ready    = (level_q < DEPTH_L);
    assign push       = i_valid && o_ready;
    assign head       = mem_q[rd_ptr_q];
    assign o_level    = level_q;
    assign o_sample   = sample_q;
    assign o_data     = data_q;
    assign o_underrun = underrun_q;

`ifdef DSM_INTERP_LINEAR_EN
    localparam int AW = DATA_WIDTH + OSR_LOG2 + 1;

    // (c*2^OSR + (n-c)*p) >>> OSR; the sum always lies between c and n scaled, so
    // modulo-2^AW arithmetic is exact and no saturation is required.
    function automatic logic signed [DATA_WIDTH-1:0] interp(
        input logic signed [DATA_WIDTH-1:0] c,
        input logic signed [DATA_WIDTH-1:0] n,
        input logic [OSR_LOG2-1:0]          p
    );
        logic signed [DATA_WIDTH:0] delta;
        logic signed [AW-1:0]       acc;
        delta  = {n[DATA_WIDTH-1], n} - {c[DATA_WIDTH-1], c};
        acc    = ({{(OSR_LOG2+1){c[DATA_WIDTH-1]}}, c} << OSR_LOG2)
               + ({{OSR_LOG2{delta[DATA_WIDTH]}}, delta} * {{(DATA_WIDTH+1){1'b0}}, p});
        interp = DATA_WIDTH'(acc >>> OSR_LOG2);
    endfunction
`endif

    // Buffer storage: written on accepted pushes; contents need no reset since level gates reads
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Buffer pointers and occupancy; simultaneous push and pop leaves the level unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Sequencer: load cur/next, then step the phase and fetch a new sample each period
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        next_d     = next_q;
        p_d        = p_q;
        underrun_d = underrun_q;
        pop        = 1'b0;
        if (!i_en) begin
            state_d    = IDLE;
            p_d        = '0;
            underrun_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (level_q >= TWO_L) begin
                        state_d = LOAD_CUR;
                    end
                end
                LOAD_CUR: begin
                    pop     = 1'b1;
                    cur_d   = head;
                    state_d = LOAD_NEXT;
                end
                LOAD_NEXT: begin
                    pop     = 1'b1;
                    next_d  = head;
                    p_d     = '0;
                    state_d = RUN;
                end
                RUN: begin
                    p_d = p_q + 1'b1;
                    if (p_q == P_LAST) begin
                        // Empty at fetch: next stays put, so cur==next and the output holds.
                        cur_d = next_q;
                        if (level_q != '0) begin
                            pop    = 1'b1;
                            next_d = head;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Outputs are computed from next-state values so they appear registered in step with p.
        sample_d = (state_d == RUN);
`ifdef DSM_INTERP_LINEAR_EN
        data_d = sample_d ? interp(cur_d, next_d, p_d) : '0;
`else
        data_d = sample_d ? cur_d : '0;
`endif
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            next_q     <= '0;
            p_q        <= '0;
            underrun_q <= 1'b0;
            sample_q   <= 1'b0;
            data_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            next_q     <= next_d;
            p_q        <= p_d;
            underrun_q <= underrun_d;
            sample_q   <= sample_d;
            data_q     <= data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

endmodule

// File: tb/tb_dsm_interp_feeder.sv
// Bench for dsm_interp_feeder with OSR_LOG2=2, FIFO_DEPTH=4; expected data follows whichever
// build (linear or hold) the DSM_INTERP_LINEAR_EN macro selects.
module tb_dsm_interp_feeder;
    localparam int DW    = 16;
    localparam int OSR   = 2;
    localparam int DEPTH = 4;
`ifdef DSM_INTERP_LINEAR_EN
    localparam bit LINEAR = 1'b1;
`else
    localparam bit LINEAR = 1'b0;
`endif

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en    = 1'b0;
    logic                 vld   = 1'b0;
    logic signed [DW-1:0] din   = '0;
    logic                 rdy;
    logic                 smp;
    logic                 und;
    logic signed [DW-1:0] dout;
    logic [2:0]           lvl;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic en;
        logic vld;
        int   din;
        logic smp;
        int   dat;
        int   lvl;
        logic rdy;
        logic und;
    } vec_t;

    vec_t vecs[40];
    int   nv = 0;

    dsm_interp_feeder #(
        .DATA_WIDTH(DW),
        .OSR_LOG2  (OSR),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_valid   (vld),
        .i_data    (din),
        .o_ready   (rdy),
        .o_sample  (smp),
        .o_data    (dout),
        .o_underrun(und),
        .o_level   (lvl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // en, vld, din -> expected sample, data (linear build), data (hold build), level, ready, underrun
    task automatic add(input logic e, input logic v, input int d, input logic s,
                       input int lin, input int zoh, input int l, input logic r, input logic u);
        vecs[nv] = '{e, v, d, s, (LINEAR ? lin : zoh), l, r, u};
        nv++;
    endtask

    initial begin
        bit got;
        int n;

        // Scenario A: 0 then 100, a third sample 200 pushed while running, then underrun
        add(0, 1, 0,    0, 0,   0,   1, 1, 0);
        add(0, 1, 100,  0, 0,   0,   2, 1, 0);
        add(1, 0, 0,    0, 0,   0,   2, 1, 0);
        add(1, 0, 0,    0, 0,   0,   1, 1, 0);
        add(1, 0, 0,    1, 0,   0,   0, 1, 0);
        add(1, 1, 200,  1, 25,  0,   1, 1, 0);
        add(1, 0, 0,    1, 50,  0,   1, 1, 0);
        add(1, 0, 0,    1, 75,  0,   1, 1, 0);
        add(1, 0, 0,    1, 100, 100, 0, 1, 0);
        add(1, 0, 0,    1, 125, 100, 0, 1, 0);
        add(1, 0, 0,    1, 150, 100, 0, 1, 0);
        add(1, 0, 0,    1, 175, 100, 0, 1, 0);
        add(1, 0, 0,    1, 200, 200, 0, 1, 1);
        add(1, 0, 0,    1, 200, 200, 0, 1, 1);
        add(0, 0, 0,    0, 0,   0,   0, 1, 0);
        // Scenario B: 0 then -3, floor rounding toward -inf
        add(0, 1, 0,    0, 0,   0,   1, 1, 0);
        add(0, 1, -3,   0, 0,   0,   2, 1, 0);
        add(1, 0, 0,    0, 0,   0,   2, 1, 0);
        add(1, 0, 0,    0, 0,   0,   1, 1, 0);
        add(1, 0, 0,    1, 0,   0,   0, 1, 0);
        add(1, 0, 0,    1, -1,  0,   0, 1, 0);
        add(1, 0, 0,    1, -2,  0,   0, 1, 0);
        add(1, 0, 0,    1, -3,  0,   0, 1, 0);
        add(1, 0, 0,    1, -3,  -3,  0, 1, 1);
        add(0, 0, 0,    0, 0,   0,   0, 1, 0);
        // Scenario C: fill to full, fifth sample held off until a pop, push+pop together
        add(0, 1, 8,    0, 0,   0,   1, 1, 0);
        add(0, 1, 24,   0, 0,   0,   2, 1, 0);
        add(0, 1, 40,   0, 0,   0,   3, 1, 0);
        add(0, 1, 56,   0, 0,   0,   4, 0, 0);
        add(0, 1, 72,   0, 0,   0,   4, 0, 0);
        add(1, 1, 72,   0, 0,   0,   4, 0, 0);
        add(1, 1, 72,   0, 0,   0,   3, 1, 0);
        add(1, 1, 72,   1, 8,   8,   3, 1, 0);
        add(1, 0, 0,    1, 12,  8,   3, 1, 0);
        add(1, 0, 0,    1, 16,  8,   3, 1, 0);

        // Reset state
        #12;
        chk("reset.sample",   smp,  0);
        chk("reset.data",     dout, 0);
        chk("reset.level",    lvl,  0);
        chk("reset.ready",    rdy,  1);
        chk("reset.underrun", und,  0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < nv; i++) begin
            en  = vecs[i].en;
            vld = vecs[i].vld;
            din = DW'(vecs[i].din);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.sample", i),   smp,  vecs[i].smp);
            chk($sformatf("v%0d.data", i),     dout, vecs[i].dat);
            chk($sformatf("v%0d.level", i),    lvl,  vecs[i].lvl);
            chk($sformatf("v%0d.ready", i),    rdy,  vecs[i].rdy);
            chk($sformatf("v%0d.underrun", i), und,  vecs[i].und);
        end

        // Asynchronous reset mid-period (phase 2): outputs clear at once, buffer discarded
        vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.sample",   smp,  0);
        chk("midrst.data",     dout, 0);
        chk("midrst.level",    lvl,  0);
        chk("midrst.ready",    rdy,  1);
        chk("midrst.underrun", und,  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("postrst%0d.sample", i), smp, 0);
            chk($sformatf("postrst%0d.level", i),  lvl, 0);
        end

        // Restart only through IDLE with two buffered samples
        en  = 1'b0;
        vld = 1'b1;
        din = 16'sd7;
        @(posedge clk);
        #1;
        din = 16'sd9;
        @(posedge clk);
        #1;
        chk("restart.level", lvl, 2);
        vld = 1'b0;
        en  = 1'b1;
        got = 1'b0;
        n   = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (smp === 1'b1) begin
                got = 1'b1;
                n   = i;
                break;
            end
        end
        chk("restart.seen",    got,  1);
        chk("restart.latency", n,    3);
        chk("restart.data",    dout, 7);
        chk("restart.level",   lvl,  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
